// File: rtl/exarbiter_pkg.sv
// Shared exbus definitions: word width, special-class prefix field and the
// arbiter state encoding.
package exarbiter_pkg;

  localparam int EXB_WORDW = 35;

  // Prefix field of an exbus word; 2'b11 marks the special/idle class.
  localparam int         EXB_PFX_MSB     = 34;
  localparam int         EXB_PFX_LSB     = 33;
  localparam logic [1:0] EXB_PFX_SPECIAL = 2'b11;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/exarbiter_rrpick.sv
// Combinational rotate-priority picker: finds the first set request bit
// searching upward from last_grant+1, wrapping modulo NS.
module exarb_rrpick #(
  parameter int NS   = 2,
  parameter int LGNS = $clog2(NS)
) (
  input  logic [NS-1:0]   i_req,
  input  logic [LGNS-1:0] i_last_grant,
  output logic            o_any,
  output logic [LGNS-1:0] o_index
);

  int              w_pos;
  logic [LGNS-1:0] w_cand;

  // Scan candidates nearest-first; the first hit wins and later hits are ignored.
  always_comb begin
    o_any   = 1'b0;
    o_index = '0;
    w_pos   = 0;
    w_cand  = '0;
    for (int off = 1; off <= NS; off++) begin
      w_pos  = (int'(i_last_grant) + off) % NS;
      w_cand = w_pos[LGNS-1:0];
      if (!o_any && i_req[w_cand]) begin
        o_any   = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/exarbiter.sv
// Packet-atomic round-robin arbiter for the exbus outgoing word channel.
// Handshake: a word moves from source k when i_stb[k] && !o_busy[k]; the
// output word is taken downstream when o_stb && !i_busy, and it is held
// unchanged while o_stb && i_busy. The grant is kept until the word flagged
// last has transferred, so packets are never interleaved.
module exarbiter
  import exarbiter_pkg::*;
#(
  parameter int   NS           = 2,
  parameter int   LGNS         = $clog2(NS),
  parameter logic OPT_LOWPOWER = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NS-1:0]           i_stb,
  input  logic [NS*EXB_WORDW-1:0] i_word,
  input  logic [NS-1:0]           i_last,
  output logic [NS-1:0]           o_busy,
  output logic                    o_stb,
  output logic [EXB_WORDW-1:0]    o_word,
  output logic                    o_last,
  input  logic                    i_busy,
  output logic [LGNS-1:0]         o_grant,
  output logic                    o_active
);

  arb_state_t             r_state;
  logic [LGNS-1:0]        r_grant;
  logic [LGNS-1:0]        r_last_grant;
  logic                   r_stb;
  logic                   r_last;
  logic [EXB_WORDW-1:0]   r_word;

  logic                   w_any;
  logic [LGNS-1:0]        w_pick;
  logic                   w_own_stb;
  logic                   w_own_last;
  logic [EXB_WORDW-1:0]   w_own_word;
  logic                   w_xfer;

  exarb_rrpick #(
    .NS   (NS),
    .LGNS (LGNS)
  ) u_pick (
    .i_req        (i_stb),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_index      (w_pick)
  );

  // Owner's request lines and the transfer condition (output empty or draining).
  always_comb begin
    w_own_stb  = i_stb[r_grant];
    w_own_last = i_last[r_grant];
    w_own_word = i_word[int'(r_grant)*EXB_WORDW +: EXB_WORDW];
    w_xfer     = (r_state == ARB_OWN) && w_own_stb && (!r_stb || !i_busy);
  end

  // Everyone stalls except the owner, which stalls only on a blocked output.
  always_comb begin
    o_busy = '1;
    if (i_reset_n && (r_state == ARB_OWN))
      o_busy[r_grant] = r_stb && i_busy;
  end

  // Arbitration FSM plus the single output register it feeds.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= LGNS'(NS-1);
      r_stb        <= 1'b0;
      r_word       <= '0;
      r_last       <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_OWN;
            r_grant <= w_pick;
          end
        end
        ARB_OWN: begin
          if (w_xfer && w_own_last) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= r_grant;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase

      if (w_xfer) begin
        r_stb  <= 1'b1;
        r_word <= w_own_word;
        r_last <= w_own_last;
      end else if (!i_busy) begin
        r_stb <= 1'b0;
        if (OPT_LOWPOWER) begin
          r_word <= '0;
          r_last <= 1'b0;
        end
      end
    end
  end

  assign o_stb    = r_stb;
  assign o_word   = r_word;
  assign o_last   = r_last;
  assign o_grant  = r_grant;
  assign o_active = (r_state == ARB_OWN);

endmodule
